// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the divider issue controller
package div_pkg;
  localparam int DIV_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
  localparam logic [DIV_W-1:0] DZ_QUO = '1;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: operand magnitudes on issue, result sign correction on retire
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  output logic [WIDTH-1:0] mag_a_o,
  output logic [WIDTH-1:0] mag_b_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  assign mag_a_o = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b_o = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign quo_o   = neg_q_i ? -quo_i : quo_i;
  assign rem_o   = neg_r_i ? -rem_i : rem_i;
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues signed/unsigned ops to a multi-cycle divider and retires results
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_W,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dz,
  output logic             out_timeout,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_finish,
  input  logic [WIDTH:0]   div_quo,
  input  logic [WIDTH-1:0] div_rem
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             finish_q, neg_q_q, neg_r_q;
  logic             in_ready_q, out_valid_q, out_dz_q, out_to_q, div_start_q;
  logic [WIDTH-1:0] out_quo_q, out_rem_q, div_a_q, div_b_q;
  logic [WIDTH-1:0] mag_a, mag_b, fix_quo, fix_rem;
  logic             fin_edge, unused_quo_msb;
  assign unused_quo_msb = div_quo[WIDTH];
  // a finish level held over from the previous op is not a completion
  assign fin_edge = div_finish && !finish_q;
  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .a_i(in_a), .b_i(in_b), .signed_i(in_signed),
    .quo_i(div_quo[WIDTH-1:0]), .rem_i(div_rem),
    .neg_q_i(neg_q_q), .neg_r_i(neg_r_q),
    .mag_a_o(mag_a), .mag_b_o(mag_b), .quo_o(fix_quo), .rem_o(fix_rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      finish_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_dz_q    <= 1'b0;
      out_to_q    <= 1'b0;
      div_start_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
    end else begin
      finish_q    <= div_finish;
      div_start_q <= 1'b0;
      unique case (state_q)
        IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          neg_q_q    <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          neg_r_q    <= in_signed && in_a[WIDTH-1];
          if (in_b == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_quo_q   <= WIDTH'(DZ_QUO);
            out_rem_q   <= in_a;
            out_dz_q    <= 1'b1;
          end else begin
            state_q     <= ISSUE;
            div_a_q     <= mag_a;
            div_b_q     <= mag_b;
            div_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: if (fin_edge) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          out_quo_q   <= fix_quo;
          out_rem_q   <= fix_rem;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          out_quo_q   <= '0;
          out_rem_q   <= '0;
          out_to_q    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_dz_q    <= 1'b0;
          out_to_q    <= 1'b0;
        end
      endcase
    end
  end
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_quo     = out_quo_q;
  assign out_rem     = out_rem_q;
  assign out_dz      = out_dz_q;
  assign out_timeout = out_to_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_start   = div_start_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized and directed checks of div_issue_ctrl against a queue-based model
module tb_div_issue_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b0, out_dz, out_timeout;
  logic [31:0] out_quo, out_rem, div_a, div_b, div_rem;
  logic        div_start, div_finish;
  logic [32:0] div_quo;
  int checks = 0, errors = 0, starts = 0;
  logic hang = 1'b0;

  typedef struct packed {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] quo, rem;
    logic        dz, to;
  } ent_t;
  ent_t q[$];

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_quo(out_quo),
    .out_rem(out_rem), .out_dz(out_dz), .out_timeout(out_timeout), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_finish(div_finish), .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // divider model: finish drops on start, rises 34 cycles later and then stays high
  logic        d_busy, d_junk;
  int          d_cnt;
  logic [31:0] d_q, d_r;
  logic        d_fin;
  assign div_finish = d_fin;
  assign div_quo = {d_junk, d_q};
  assign div_rem = d_r;
  always @(posedge clk) begin
    if (rst) begin
      d_fin <= 1'b0; d_busy <= 1'b0; d_cnt <= 0; d_q <= '0; d_r <= '0; d_junk <= 1'b0;
    end else if (div_start) begin
      starts <= starts + 1;
      d_busy <= 1'b1; d_cnt <= 0; d_fin <= 1'b0;
      d_q <= div_a / div_b; d_r <= div_a % div_b; d_junk <= 1'($urandom_range(0, 1));
    end else if (d_busy && !hang) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == 33) begin d_fin <= 1'b1; d_busy <= 1'b0; end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sval(input logic [31:0] x, input logic s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    longint v = sval(x, s);
    return 32'(v < 0 ? -v : v);
  endfunction

  function automatic ent_t model(input logic [31:0] a, b, input logic s, input logic hung);
    ent_t e;
    longint sa, sb;
    e = '{a: a, b: b, s: s, quo: '0, rem: '0, dz: 1'b0, to: 1'b0};
    sa = sval(a, s); sb = sval(b, s);
    if (b == 0) begin e.quo = '1; e.rem = a; e.dz = 1'b1; end
    else if (hung) e.to = 1'b1;
    else begin e.quo = 32'(sa / sb); e.rem = 32'(sa % sb); end
    return e;
  endfunction

  // compare process: outputs against the model queue every cycle out of reset
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      chk("in_ready", in_ready, q.size() == 0);
      if (div_start) begin
        chk("div_start_inflight", q.size(), 1);
        if (q.size() > 0) begin
          chk("div_a_mag", div_a, mag(q[0].a, q[0].s));
          chk("div_b_mag", div_b, mag(q[0].b, q[0].s));
        end
      end
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_unexpected", out_valid, 0);
        else begin
          chk("out_quo", out_quo, q[0].quo);
          chk("out_rem", out_rem, q[0].rem);
          chk("out_dz", out_dz, q[0].dz);
          chk("out_timeout", out_timeout, q[0].to);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_signed, hang));
    end
  end

  task automatic send(input logic [31:0] a, b, input logic s);
    int n = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic s, input int stall,
                        input logic [31:0] ea, eq, er, input logic edz, eto);
    int n = 0, st0;
    st0 = starts;
    send(a, b, s);
    if (b == 0) chk("dz_latency", out_valid, 1);
    else begin
      chk("start_pulse", div_start, 1);
      chk("div_a_lit", div_a, ea);
    end
    while (!out_valid && n < 400) begin @(posedge clk); #1; n++; end
    chk("result_seen", out_valid, 1);
    chk("lit_quo", out_quo, eq);
    chk("lit_rem", out_rem, er);
    chk("lit_dz", out_dz, edz);
    chk("lit_to", out_timeout, eto);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_quo", out_quo, eq);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("start_count", starts - st0, (b != 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    logic rdone;
    e = model(32'd351, 32'd23, 1'b0, 1'b0);         chk("pin_u_quo", e.quo, 15);
    e = model(32'hFFFFFEA1, 32'd23, 1'b1, 1'b0);    chk("pin_s_rem", e.rem, 32'hFFFFFFFA);
    e = model(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0); chk("pin_ovf_quo", e.quo, 32'h80000000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_quo", out_quo, 0);
    chk("rst_flags", {out_dz, out_timeout}, 0);
    run_op(32'd351, 32'd23, 1'b0, 0, 32'd351, 32'd15, 32'd6, 1'b0, 1'b0);
    run_op(32'hFFFFFEA1, 32'h17, 1'b1, 0, 32'd351, 32'hFFFFFFF1, 32'hFFFFFFFA, 1'b0, 1'b0);
    run_op(32'd351, 32'hFFFFFFE9, 1'b1, 0, 32'd351, 32'hFFFFFFF1, 32'd6, 1'b0, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 32'h80000000, 32'h80000000, 32'd0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 0, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0);
    run_op(32'd1000, 32'd7, 1'b0, 10, 32'd1000, 32'd142, 32'd6, 1'b0, 1'b0);
    run_op(32'hFFFFFF9C, 32'd7, 1'b1, 0, 32'd100, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
    hang = 1'b1;
    run_op(32'd9, 32'd4, 1'b0, 0, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1);
    send(32'd7, 32'd2, 1'b0);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    hang = 1'b0;
    run_op(32'd100, 32'd9, 1'b0, 0, 32'd100, 32'd11, 32'd1, 1'b0, 1'b0);
    rdone = 1'b0;
    fork
      begin
        logic [31:0] sp[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1};
        logic [31:0] a, b;
        int n = 0;
        for (int i = 0; i < 40; i++) begin
          a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
          b = ($urandom_range(0, 7) == 0) ? 32'h0 :
              ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 60)) : $urandom;
          send(a, b, 1'($urandom_range(0, 1)));
        end
        while (q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("drain", q.size(), 0);
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
